// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit for the execute stage.
// One bit per cycle: shift-add multiply, restoring divide.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   m;
    logic               op_div;
    logic               sign_res;
    logic               sign_a;
    logic               dz;

    logic               zero_div;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy = (state != IDLE);

    always_comb begin
        zero_div = op[1] && (b == '0);
        abs_a    = (op[0] && a[WIDTH-1]) ? -a : a;
        abs_b    = (op[0] && b[WIDTH-1]) ? -b : b;
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m};
        mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                          : {1'b0, acc[2*WIDTH-1:1]};
        // Remainder needs one extra bit after the shift before the trial
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        trial    = rem_sh - {1'b0, m};
        div_next = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod_fix = sign_res ? -acc : acc;
        quo_fix  = sign_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = zero_div ? FIX : CALC;
            CALC:    if (cnt == '0) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            acc      <= '0;
            m        <= '0;
            op_div   <= 1'b0;
            sign_res <= 1'b0;
            sign_a   <= 1'b0;
            dz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_div   <= op[1];
                        sign_res <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sign_a   <= op[0] & a[WIDTH-1];
                        dz       <= zero_div;
                        cnt      <= CW'(WIDTH - 1);
                        m        <= op[1] ? abs_b : abs_a;
                        acc      <= {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                    acc <= op_div ? div_next : mul_next;
                end
                FIX: begin
                    if (!dz) begin
                        if (op_div) begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                    done     <= 1'b1;
                    div_zero <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed MULT/DIV/MTHI/MTLO vectors.
// Expected results are queued at issue and checked when done pulses.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .hi_we(hi_we),
        .lo_we(lo_we),
        .wdata(wdata),
        .busy(busy),
        .done(done),
        .div_zero(div_zero),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst && (done || div_zero)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=%b with empty queue",
                         done);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_hi"}, hi, e.hi);
                chk({e.name, "_lo"}, lo, e.lo);
                chk({e.name, "_dz"}, W'(div_zero), W'(e.dz));
                chk({e.name, "_done"}, W'(done), W'(1));
                chk({e.name, "_busy"}, W'(busy), W'(0));
                chk({e.name, "_cycle"}, W'(cyc), W'(e.cyc));
            end
        end
    end

    // Call just after a negedge; returns #1 after the start edge E0
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] eh,
                         input logic [W-1:0] el, input logic edz,
                         input int lat, input string nm,
                         input logic hw = 1'b0, input logic lw = 1'b0,
                         input logic [W-1:0] wd = '0);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        hi_we = hw;
        lo_we = lw;
        wdata = wd;
        @(posedge clk);
        #1;
        e.hi   = eh;
        e.lo   = el;
        e.dz   = edz;
        e.cyc  = cyc + lat;
        e.name = nm;
        sb.push_back(e);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout: got no done expected done within 100",
                     nm);
        end
    endtask

    task automatic mt_write(input logic hw, input logic lw,
                            input logic [W-1:0] wd);
        @(negedge clk);
        hi_we = hw;
        lo_we = lw;
        wdata = wd;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int nb;
        logic held;
        logic [W-1:0] h0;
        logic [W-1:0] l0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_div_zero", W'(div_zero), '0);
        @(negedge clk);
        rst = 1'b1;

        @(negedge clk);
        h0 = hi;
        l0 = lo;
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, "multu_max");
        nb = 0;
        held = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
            if (busy) nb++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
        end
        chk("multu_busy_cycles", W'(nb), W'(33));
        chk("multu_hold_during_calc", W'(held), W'(1));

        @(negedge clk);
        issue(2'b01, 32'hFFFF_FFFD, 32'd7,
              32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, "mult_mixed");
        wait_done("mult_mixed");

        @(negedge clk);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, "div_neg");
        wait_done("div_neg");

        @(negedge clk);
        issue(2'b10, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 33, "divu_7_2");
        wait_done("divu_7_2");

        @(negedge clk);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h0, 32'h8000_0000, 1'b0, 33, "div_overflow");
        wait_done("div_overflow");

        mt_write(1'b1, 1'b0, 32'h1234);
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_lo_kept", lo, 32'h8000_0000);
        issue(2'b10, 32'd5, 32'd0,
              32'h1234, 32'h8000_0000, 1'b1, 1, "divu_zero");
        wait_done("divu_zero");

        mt_write(1'b1, 1'b1, 32'hA5A5);
        chk("mt_both_hi", hi, 32'hA5A5);
        chk("mt_both_lo", lo, 32'hA5A5);

        @(negedge clk);
        issue(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33,
              "start_beats_write", 1'b1, 1'b0, 32'hDEAD);
        @(negedge clk);
        chk("write_dropped_hi", hi, 32'hA5A5);
        wait_done("start_beats_write");

        @(negedge clk);
        issue(2'b00, 32'h0001_0000, 32'h0001_0000,
              32'd1, 32'd0, 1'b0, 33, "busy_protect");
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd9;
        b     = 32'd3;
        hi_we = 1'b1;
        wdata = 32'hBEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        @(negedge clk);
        chk("busy_write_ignored", hi, 32'd0);
        chk("busy_mid_calc", W'(busy), W'(1));
        wait_done("busy_protect");

        issue(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33, "back_to_back");
        wait_done("back_to_back");

        @(negedge clk);
        issue(2'b11, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 33, "div_aborted");
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        sb.delete();
        chk("abort_busy", W'(busy), '0);
        chk("abort_done", W'(done), '0);
        chk("abort_hi", hi, '0);
        chk("abort_lo", lo, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 33, "multu_after_rst");
        wait_done("multu_after_rst");

        repeat (3) @(negedge clk);
        chk("queue_drained", W'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle integer multiply/divide unit with architectural HI/LO registers, parametrised in operand width. It sits beside the ALU in the execute stage and gives the core MULT, MULTU, DIV, DIVU, MTHI and MTLO, which the single-cycle datapath cannot provide. The core asserts `start`, stalls on `busy`, and reads `hi`/`lo` after `done`. The unit runs iteratively: radix-2 shift-add multiply and restoring division, one bit per cycle.

## Interface
- `WIDTH`, default 32: operand, HI and LO width; must be even and at least 4.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  request a new operation; sampled only when `busy`=0
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- `a`  in  WIDTH  multiplicand or dividend (Rs)
- `b`  in  WIDTH  multiplier or divisor (Rt)
- `hi_we`  in  1  MTHI: write `wdata` to HI
- `lo_we`  in  1  MTLO: write `wdata` to LO
- `wdata`  in  WIDTH  MTHI/MTLO data
- `busy`  out  1  operation in progress; core must stall HI/LO reads
- `done`  out  1  one-cycle pulse: HI/LO hold the new result
- `div_zero`  out  1  one-cycle pulse with `done`: division by zero occurred
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE:**
  - `start`=1 latches `op`, |a|, |b|, the result sign and the dividend sign, loads the bit counter with WIDTH-1, and moves to CALC.
  - Exception: DIV/DIVU with `b`=0 moves directly to FIX with the zero flag set.
- **CALC:** one iteration per cycle. The state moves to FIX when the counter reaches 0, so CALC lasts exactly WIDTH cycles.
  - **Multiply:** 2·WIDTH-bit accumulator. If the multiplier LSB is 1, add the multiplicand to the upper half, then shift right one bit, keeping the carry.
  - **Divide:** shift the remainder:quotient pair left one bit. Trial-subtract the divisor from the remainder. If the result is non-negative, keep it and set the quotient LSB to 1.
- **FIX:** one cycle, then back to IDLE.
  - Signed ops apply two's-complement negation to the magnitudes.
  - Product and quotient take the sign `a`[MSB]^`b`[MSB]; the remainder takes the sign of `a`.
  - Multiply: HI=product[2W-1:W], LO=product[W-1:0]. Divide: LO=quotient, HI=remainder.
  - All arithmetic is modulo 2^WIDTH per half. DIV of the most-negative value by -1 gives LO=most-negative and HI=0, with no flag.
  - Divide by zero: HI and LO are left unchanged, and `div_zero`=1.
- **MTHI/MTLO:** `hi_we`/`lo_we` write in IDLE only.
  - Writes are ignored while `busy`=1.
  - If `start` and a write occur in the same cycle, the start is taken and the write is dropped.
  - `hi_we` and `lo_we` together write both registers.
- **Result visibility:** HI and LO change only at the FIX edge or on an MTHI/MTLO write. They hold their previous values throughout CALC.
- **Start while busy:** ignored. No queueing, and no error is signalled.

## Timing
- **Reset:** async assertion forces IDLE. `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, counter=0. An in-flight operation is discarded.
- Let edge E0 be the edge where `start` is sampled.
- **Normal operation:**
  - `busy`=1 from E0 through the FIX edge, E(WIDTH+1).
  - HI/LO update at E(WIDTH+1).
  - `done`=1 and `busy`=0 in the cycle after E(WIDTH+1).
  - Latency is WIDTH+1 edges: 33 for WIDTH=32.
- **Divide by zero:** FIX occurs at E1. `done` and `div_zero` are high in the cycle after E1 (latency 1 edge).
- **Back-to-back operations:** a `start` sampled in the `done` cycle is accepted, so the next E0 coincides with the `done` cycle. Throughput is one operation per WIDTH+2 cycles.
- **Outputs:** `done` and `div_zero` are registered and last exactly one cycle. All outputs are registered.

## Test plan
- **MULTU, unsigned extremes:** WIDTH=32, `a`=`b`=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. `done` in the cycle after E33, `busy` high for 33 cycles.
- **MULT, mixed signs:** `a`=-3, `b`=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- **DIV vs DIVU:** DIV `a`=-7, `b`=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU `a`=7, `b`=2 -> LO=3, HI=1. DIV `a`=0x80000000, `b`=0xFFFFFFFF -> LO=0x80000000, HI=0.
- **Divide by zero:** MTHI 0x1234, then DIVU `b`=0 -> `done` and `div_zero` in the cycle after E1; HI=0x1234 and LO unchanged.
- **Busy protection and back-to-back:**
  - A `start` and `hi_we` issued mid-CALC are ignored, and the result matches the first operation.
  - A new MULTU issued in the `done` cycle completes 33 edges later.
- **Reset mid-operation:** drive `rst` low at cycle 10 of a DIV -> `busy`, `done`, `hi` and `lo` all read 0 immediately. After release, a fresh MULTU 5×6 gives LO=30, HI=0.
